// File: rtl/l1_miss_handler.sv
// L1 miss handler: takes the L1 tag lookup result for each coalesced request
// and services one outstanding miss at a time. While a miss is open it stalls
// the memory pipeline and probes the L2 tag unit. It then models the fill
// latency: the L2 delay on an L2 hit, or the DRAM delay on an L2 miss.
// Finally it writes the missing line's tag back into the L1 tag store.
module l1_miss_handler #(
  parameter int ADDR_W     = 32,
  parameter int SEG_W      = 5,
  parameter int LINE_LOG   = 7,
  parameter int L2_DELAY   = 20,
  parameter int DRAM_DELAY = 400,
  parameter int CNT_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [SEG_W-1:0]  req_seg,
  input  logic              l1_hit,
  output logic              stall_o,
  output logic              l2_lookup_valid,
  output logic [ADDR_W-1:0] l2_lookup_addr,
  input  logic              l2_resp_valid,
  input  logic              l2_hit,
  output logic              l1_tag_write,
  output logic [ADDR_W-1:0] l1_tag_write_addr,
  output logic              fill_done,
  output logic [SEG_W-1:0]  fill_seg,
  output logic [CNT_W-1:0]  miss_delay
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RESP,
    WAIT,
    FILL
  } state_t;

  // Clears the byte-offset bits so the latched address names a whole line.
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-LINE_LOG){1'b1}}, {LINE_LOG{1'b0}}};
  // The WAIT countdown runs through zero inclusive, so each load is one
  // below the fill latency it models.
  localparam logic [CNT_W-1:0] L2_LOAD   = CNT_W'(L2_DELAY - 1);
  localparam logic [CNT_W-1:0] DRAM_LOAD = CNT_W'(DRAM_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] line_addr;
  logic [SEG_W-1:0]  seg_q;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  dly;
  logic              miss;

  assign miss = req_valid & ~l1_hit;

  // While a miss is open, the latched line address goes to both the L2
  // probe and the L1 tag write.
  assign l2_lookup_addr    = line_addr;
  assign l1_tag_write_addr = line_addr;
  assign miss_delay        = fill_done ? stall_cnt : '0;
  assign fill_seg          = fill_done ? seg_q : '0;

  // State register; a reset in any state abandons an open miss.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and strobe decode; the stall is raised in the miss cycle itself.
  always_comb begin
    state_next      = state;
    stall_o         = 1'b0;
    l2_lookup_valid = 1'b0;
    l1_tag_write    = 1'b0;
    fill_done       = 1'b0;
    case (state)
      IDLE: begin
        if (miss) begin
          stall_o    = 1'b1;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        stall_o         = 1'b1;
        l2_lookup_valid = 1'b1;
        state_next      = RESP;
      end
      RESP: begin
        stall_o = 1'b1;
        if (l2_resp_valid) state_next = WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dly == '0) state_next = FILL;
      end
      FILL: begin
        l1_tag_write = 1'b1;
        fill_done    = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Miss bookkeeping: latch the line and segment, count stall cycles and run the fill countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_addr <= '0;
      seg_q     <= '0;
      stall_cnt <= '0;
      dly       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            line_addr <= req_addr & LINE_MASK;
            seg_q     <= req_seg;
            stall_cnt <= CNT_W'(1);
          end
        end
        LOOKUP: begin
          if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
        end
        RESP: begin
          if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
          if (l2_resp_valid) dly <= l2_hit ? L2_LOAD : DRAM_LOAD;
        end
        WAIT: begin
          if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
          if (dly != '0) dly <= dly - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_miss_handler.sv
// Directed testbench for l1_miss_handler. Inputs change 1 time unit after
// each rising edge, and outputs are sampled 1 time unit after that.
module tb_l1_miss_handler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [4:0]  req_seg;
  logic        l1_hit;
  logic        stall_o;
  logic        l2_lookup_valid;
  logic [31:0] l2_lookup_addr;
  logic        l2_resp_valid;
  logic        l2_hit;
  logic        l1_tag_write;
  logic [31:0] l1_tag_write_addr;
  logic        fill_done;
  logic [4:0]  fill_seg;
  logic [9:0]  miss_delay;

  int checks = 0;
  int errors = 0;

  l1_miss_handler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_seg(req_seg), .l1_hit(l1_hit), .stall_o(stall_o),
    .l2_lookup_valid(l2_lookup_valid), .l2_lookup_addr(l2_lookup_addr),
    .l2_resp_valid(l2_resp_valid), .l2_hit(l2_hit), .l1_tag_write(l1_tag_write),
    .l1_tag_write_addr(l1_tag_write_addr), .fill_done(fill_done),
    .fill_seg(fill_seg), .miss_delay(miss_delay)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one miss and follows it to the fill. The L2 reply arrives resp_wait
  // cycles after the LOOKUP cycle. The optional spurious l2_resp_valid pulse
  // lands in WAIT. With hold set, a second missing request is kept on the
  // inputs from the cycle after the miss, including the FILL cycle.
  task automatic run_miss(input string name, input logic [31:0] addr, input logic [4:0] seg,
                          input logic hit, input int resp_wait, input logic spur,
                          input logic hold, input logic [31:0] hold_addr, input logic [4:0] hold_seg,
                          input logic [31:0] exp_line, input int exp_stall);
    int   stalls = 0, lookups = 0, lk = -1, tw_bad = 0;
    logic done = 1'b0, stall_at_fill = 1'b1;
    logic [31:0] look_addr = '0, tw_addr = '0;
    logic [9:0]  md = '0;
    logic [4:0]  fs = '0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(posedge clk); #1;
      req_valid     = (c == 0) || hold;
      req_addr      = (c == 0) ? addr : hold_addr;
      req_seg       = (c == 0) ? seg : hold_seg;
      l1_hit        = 1'b0;
      l2_hit        = hit;
      l2_resp_valid = (lk >= 0) && ((c == lk + resp_wait) || (spur && c == lk + resp_wait + 3));
      #1;
      if (stall_o) stalls++;
      if (l2_lookup_valid) begin
        lookups++;
        lk = c;
        look_addr = l2_lookup_addr;
      end
      if (l1_tag_write !== fill_done) tw_bad++;
      if (fill_done) begin
        done = 1'b1;
        stall_at_fill = stall_o;
        tw_addr = l1_tag_write_addr;
        md = miss_delay;
        fs = fill_seg;
      end
    end
    req_valid     = hold;
    l2_resp_valid = 1'b0;
    check({name, " fill_done_seen"}, 32'(done), 32'd1);
    check({name, " lookup_count"}, 32'(lookups), 32'd1);
    check({name, " l2_lookup_addr"}, look_addr, exp_line);
    check({name, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({name, " stall_in_fill"}, 32'(stall_at_fill), 32'd0);
    check({name, " tag_write_eq_fill_done"}, 32'(tw_bad), 32'd0);
    check({name, " l1_tag_write_addr"}, tw_addr, exp_line);
    check({name, " miss_delay"}, 32'(md), 32'(exp_stall));
    check({name, " fill_seg"}, 32'(fs), 32'(seg));
  endtask

  initial begin
    int bad;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_seg = '0; l1_hit = 1'b0;
    l2_resp_valid = 1'b0; l2_hit = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; #1;
    check("reset stall_o", 32'(stall_o), 32'd0);
    check("reset l2_lookup_valid", 32'(l2_lookup_valid), 32'd0);
    check("reset l2_lookup_addr", l2_lookup_addr, 32'd0);
    check("reset l1_tag_write", 32'(l1_tag_write), 32'd0);
    check("reset fill_done", 32'(fill_done), 32'd0);
    check("reset miss_delay", 32'(miss_delay), 32'd0);

    // 1: all requests hit in L1
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 32'h0000_1000 + 32'(c * 4); l1_hit = 1'b1;
      #1;
      if (stall_o || l2_lookup_valid || l1_tag_write || fill_done) bad++;
    end
    check("hits no stall/lookup/write", 32'(bad), 32'd0);
    @(posedge clk); #1; req_valid = 1'b0; l1_hit = 1'b0;

    // 2: L2 hit, response one cycle after LOOKUP
    run_miss("t2", 32'h0000_12F4, 5'h02, 1'b1, 1, 1'b0, 1'b0, '0, '0, 32'h0000_1280, 23);

    // 3: L2 miss, DRAM fill
    run_miss("t3", 32'hABCD_0155, 5'h13, 1'b0, 1, 1'b0, 1'b0, '0, '0, 32'hABCD_0100, 403);

    // 4: a stray response in IDLE, a reply delayed 5 cycles and a stray in WAIT
    @(posedge clk); #1; l2_resp_valid = 1'b1; l2_hit = 1'b0; #1;
    check("t4 idle resp no lookup", 32'(l2_lookup_valid), 32'd0);
    check("t4 idle resp no stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1; l2_resp_valid = 1'b0; #1;
    check("t4 idle resp still idle", 32'(stall_o | l2_lookup_valid), 32'd0);
    run_miss("t4", 32'h0000_4FFF, 5'h0A, 1'b1, 5, 1'b1, 1'b0, '0, '0, 32'h0000_4F80, 27);

    // 5: reset mid DRAM fill
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h0000_7733; req_seg = 5'h09; l1_hit = 1'b0; l2_hit = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1; l2_resp_valid = 1'b1;
    @(posedge clk); #1; l2_resp_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (!stall_o || l1_tag_write) bad++;
    end
    check("t5 stalled in WAIT", 32'(bad), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; #1;
    check("t5 stall_o after reset", 32'(stall_o), 32'd0);
    check("t5 l1_tag_write after reset", 32'(l1_tag_write), 32'd0);
    check("t5 fill_done after reset", 32'(fill_done), 32'd0);
    check("t5 l2_lookup_addr after reset", l2_lookup_addr, 32'd0);
    check("t5 fill_seg after reset", 32'(fill_seg), 32'd0);
    check("t5 miss_delay after reset", 32'(miss_delay), 32'd0);
    bad = 0;
    for (int c = 0; c < 450; c++) begin
      @(posedge clk); #1;
      if (l1_tag_write || fill_done || stall_o) bad++;
    end
    check("t5 no tag write for dropped miss", 32'(bad), 32'd0);

    // 6: second miss held through the FILL cycle, taken in the next IDLE cycle
    run_miss("t6a", 32'h0000_2000, 5'h03, 1'b1, 1, 1'b0, 1'b1, 32'h0000_3081, 5'h07, 32'h0000_2000, 23);
    run_miss("t6b", 32'h0000_3081, 5'h07, 1'b1, 1, 1'b0, 1'b0, '0, '0, 32'h0000_3080, 23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
